// File: rtl/branch_hazard_unit.sv
// ---------------------------------------------------------------------------
// branch_hazard_unit
//
// Decode-stage branch resolution and hazard detection for the 5-stage MIPS
// pipeline. Branches resolve in ID by comparing the two register-file read
// operands. The unit raises the stall that freezes PC and IF/ID and inserts a
// bubble into ID/EX. It also produces the taken/flush pulse that redirects
// fetch.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   src1         in   5   rs index of the instruction in ID
//   src2         in   5   rt/rd index read by the instruction in ID
//   exe_dest     in   5   destination register of the instruction in EX
//   exe_wb_en    in   1   EX instruction writes a register
//   exe_mem_r_en in   1   EX instruction is a load
//   is_br        in   1   ID instruction is a conditional branch
//   br_type      in   2   00 BEQ, 01 BNE, 10 BLTZ, 11 BGTZ
//   reg1         in  32   register-file value of src1
//   reg2         in  32   register-file value of src2
//   cond_true    out  1   branch condition holds
//   hz_out       out  1   stall PC/IF-ID and zero ID/EX control
//   hz_out_2     out  1   second-cycle stall for a load-to-branch dependency
//   br_taken     out  1   branch taken this cycle
//   if_flush     out  1   flush IF/ID (same as br_taken)
// ---------------------------------------------------------------------------
module branch_hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  src1,
    input  logic [4:0]  src2,
    input  logic [4:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic        is_br,
    input  logic [1:0]  br_type,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    output logic        cond_true,
    output logic        hz_out,
    output logic        hz_out_2,
    output logic        br_taken,
    output logic        if_flush
);

    logic match_s;
    logic load_hz_s;
    logic br_alu_hz_s;
    logic cond_s;
    logic hz_s;
    logic pend_r;

    // Hazard classification: a load in EX always wins over the ALU case, and
    // register 0 is hard-wired so it can never produce a dependency.
    always_comb begin
        match_s     = 1'b0;
        load_hz_s   = 1'b0;
        br_alu_hz_s = 1'b0;
        if (exe_dest != 5'd0) begin
            match_s = (exe_dest == src1) || (exe_dest == src2);
        end else begin
            match_s = 1'b0;
        end
        load_hz_s   = exe_mem_r_en & match_s;
        br_alu_hz_s = is_br & exe_wb_en & ~exe_mem_r_en & match_s;
    end

    // Signed branch condition; BLTZ/BGTZ only look at reg1.
    always_comb begin
        cond_s = 1'b0;
        case (br_type)
            2'b00:   cond_s = (reg1 == reg2);
            2'b01:   cond_s = (reg1 != reg2);
            2'b10:   cond_s = reg1[31];
            2'b11:   cond_s = ~reg1[31] & (reg1 != 32'd0);
            default: cond_s = 1'b0;
        endcase
    end

    // Second bubble for load-to-branch: next cycle the load sits in MEM and
    // EX holds the bubble, so the pending bit covers that cycle. It is a
    // one-cycle pulse that only reloads when a new load-branch pair appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= load_hz_s & is_br;
        end
    end

    // Stall and redirect decisions; no branch is taken while stalled.
    always_comb begin
        hz_s = 1'b0;
        hz_s = load_hz_s | br_alu_hz_s | pend_r;
    end

    assign cond_true = cond_s;
    assign hz_out    = hz_s;
    assign hz_out_2  = pend_r;
    assign br_taken  = is_br & cond_s & ~hz_s;
    assign if_flush  = is_br & cond_s & ~hz_s;

endmodule

// File: tb/tb_branch_hazard_unit.sv
module tb_branch_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_r_en;
    logic        is_br;
    logic [1:0]  br_type;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        cond_true;
    logic        hz_out;
    logic        hz_out_2;
    logic        br_taken;
    logic        if_flush;

    typedef struct {
        string       name;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [4:0]  exe_dest;
        logic        exe_wb_en;
        logic        exe_mem_r_en;
        logic        is_br;
        logic [1:0]  br_type;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic        cond;
        logic        hz;
        logic        hz2;
        logic        taken;
    } vec_t;

    typedef struct {
        string name;
        logic  cond;
        logic  hz;
        logic  hz2;
        logic  taken;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[$];
    int   errors;
    int   checks;

    branch_hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src1         (src1),
        .src2         (src2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .is_br        (is_br),
        .br_type      (br_type),
        .reg1         (reg1),
        .reg2         (reg2),
        .cond_true    (cond_true),
        .hz_out       (hz_out),
        .hz_out_2     (hz_out_2),
        .br_taken     (br_taken),
        .if_flush     (if_flush)
    );

    // Free-running clock, rising edges at multiples of 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string name, input string sig, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s.%s: got %b expected %b", name, sig, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current DUT outputs.
    task automatic check_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard: queue empty, got 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            cmp(e.name, "cond_true", cond_true, e.cond);
            cmp(e.name, "hz_out",    hz_out,    e.hz);
            cmp(e.name, "hz_out_2",  hz_out_2,  e.hz2);
            cmp(e.name, "br_taken",  br_taken,  e.taken);
            cmp(e.name, "if_flush",  if_flush,  e.taken);
        end
    endtask

    task automatic set_in(input vec_t v);
        src1         = v.src1;
        src2         = v.src2;
        exe_dest     = v.exe_dest;
        exe_wb_en    = v.exe_wb_en;
        exe_mem_r_en = v.exe_mem_r_en;
        is_br        = v.is_br;
        br_type      = v.br_type;
        reg1         = v.reg1;
        reg2         = v.reg2;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.name  = v.name;
        e.cond  = v.cond;
        e.hz    = v.hz;
        e.hz2   = v.hz2;
        e.taken = v.taken;
        sb_q.push_back(e);
    endtask

    // One cycle: drive on the falling edge, sample 2 time units later.
    task automatic apply(input vec_t v);
        @(negedge clk);
        set_in(v);
        push_exp(v);
        #2;
        check_out();
    endtask

    function automatic vec_t mk(input string name,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                input logic wb, input logic mr, input logic br, input logic [1:0] bt,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic c, input logic h, input logic h2, input logic t);
        vec_t v;
        v.name = name; v.src1 = s1; v.src2 = s2; v.exe_dest = d;
        v.exe_wb_en = wb; v.exe_mem_r_en = mr; v.is_br = br; v.br_type = bt;
        v.reg1 = r1; v.reg2 = r2;
        v.cond = c; v.hz = h; v.hz2 = h2; v.taken = t;
        return v;
    endfunction

    initial begin
        vec_t lb0;
        vec_t lb_bub;
        errors = 0;
        checks = 0;

        // name, src1, src2, dest, wb, mr, br, type, reg1, reg2 -> cond, hz, hz2, taken
        tbl.push_back(mk("load_use_nb",    5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("load_use_clear", 5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("alu_br_hz",      5'd3, 5'd1, 5'd3, 1'b1, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("alu_br_nomatch", 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("reg0_load",      5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("beq_eq",         5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h12345678, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("bne_eq",         5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("bne_ne",         5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("bltz_min",       5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h80000000, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("bltz_max",       5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h7fffffff, 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("bgtz_zero",      5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 32'd0, 32'd9, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("bgtz_one",       5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("bgtz_neg",       5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h80000000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("not_branch",     5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd42, 32'd42, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("load_use_src2",  5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk("alu_nonbranch",  5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk("nowb_br_match",  5'd6, 5'd2, 5'd6, 1'b0, 1'b0, 1'b1, 2'b00, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk("alu_br_src2",    5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 2'b01, 32'd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0));

        lb0    = mk("ld_br_c0",  5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        lb_bub = mk("ld_br_c1",  5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset state: pend cleared, combinational outputs follow inputs.
        rst_n = 1'b0;
        set_in(mk("rst_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        push_exp(mk("rst_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        check_out();
        // Load-branch pair during reset: stall shows, but no second stall follows.
        apply(lb0);
        apply(mk("rst_no_pend", 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Load-to-branch: two bubbles, then the branch resolves.
        apply(lb0);
        apply(lb_bub);
        apply(mk("ld_br_c2", 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));

        // Back-to-back load-branch pairs: pend reloads while stall persists.
        apply(lb0);
        apply(mk("ld_br_again", 5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b1, 1'b1, 1'b0));
        apply(lb_bub);
        apply(mk("ld_br_final", 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));

        // Reset between the first and second stall cancels the second.
        apply(lb0);
        @(posedge clk);
        #1;
        set_in(lb_bub);
        push_exp(lb_bub);
        check_out();
        #1;
        rst_n = 1'b0;
        #1;
        push_exp(mk("rst_mid", 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        check_out();
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk("rst_release", 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0, 1'b1));
        apply(mk("rst_after", 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0));

        if (sb_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_hazard_unit.md
# branch_hazard_unit

Decode-stage branch resolution and hazard block for the 5-stage pipelined MIPS core. It compares the two register-file read operands to resolve the branch condition, and raises the stall signals that freeze PC/IF-ID and insert a bubble. It also produces the taken/flush signal that redirects fetch. It sits between the register file read ports and the control/fetch logic of the ID stage.

## Interface
Parameters: none (data width fixed at 32, register index width fixed at 5).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- src1  in  5  rs index of the instruction in ID
- src2  in  5  rt (or rd) index read by the instruction in ID
- exe_dest  in  5  destination register of the instruction in EX
- exe_wb_en  in  1  EX instruction writes a register
- exe_mem_r_en  in  1  EX instruction is a load
- is_br  in  1  instruction in ID is a conditional branch
- br_type  in  2  00 BEQ, 01 BNE, 10 BLTZ, 11 BGTZ
- reg1  in  32  register-file value of src1
- reg2  in  32  register-file value of src2
- cond_true  out  1  branch condition holds
- hz_out  out  1  stall: hold PC and IF/ID, zero ID/EX control
- hz_out_2  out  1  second-cycle stall for a load-to-branch dependency
- br_taken  out  1  branch taken this cycle
- if_flush  out  1  flush IF/ID; equals br_taken

## Operation
- Operand match: match = (exe_dest != 0) & ((exe_dest == src1) | (exe_dest == src2)). Register 0 never causes a hazard.
- Load-use hazard: load_hz = exe_mem_r_en & match. This applies to any instruction, branch or not.
- Branch-ALU hazard: br_alu_hz = is_br & exe_wb_en & ~exe_mem_r_en & match. A branch resolves in ID, so it cannot use an EX result.
- Pending register pend (1 bit, the only state):
  - Next pend = load_hz & is_br.
  - A branch dependent on a load needs two bubbles. Cycle 1 is covered by load_hz. In cycle 2 the load is in MEM and EX holds the bubble, so pend supplies the second stall.
  - pend is a single-cycle pulse; it is never self-sustaining.
- hz_out = load_hz | br_alu_hz | pend.
- hz_out_2 = pend.
- Condition check (combinational, signed 32-bit):
  - 00: reg1 == reg2
  - 01: reg1 != reg2
  - 10: reg1 < 0, which is reg1[31]
  - 11: reg1 > 0, which is ~reg1[31] & (reg1 != 0)
  - For types 10 and 11, reg2 is ignored.
- Branch decision: br_taken = is_br & cond_true & ~hz_out. No branch is taken while stalled; the condition is re-evaluated on the cycle the stall releases.
- if_flush = br_taken.

## Timing
- cond_true, br_taken, if_flush, hz_out: purely combinational from the inputs and pend, with zero-cycle latency.
- hz_out_2: registered, asserted exactly one cycle after a cycle with load_hz & is_br.
- Reset:
  - rst_n low clears pend asynchronously, so hz_out_2 = 0 immediately.
  - During reset, hz_out, cond_true, br_taken and if_flush follow their combinational equations with pend = 0.
  - Reset asserted mid-sequence, between the first and second load-branch stall, cancels the second stall.
- Simultaneous events:
  - If pend = 1 and a new load_hz & is_br occurs in the same cycle, hz_out stays high and pend reloads to 1.
  - exe_mem_r_en & exe_wb_en together is classified as a load (load_hz), not br_alu_hz.
- No handshake; the consumer samples the outputs combinationally each cycle.

## Test plan
- Load-use, non-branch: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1=5, is_br=0 -> hz_out=1, hz_out_2=0. Next cycle, with exe_mem_r_en=0 and exe_dest=0: hz_out=0.
- Load-to-branch: cycle 0 has exe_mem_r_en=1, exe_dest=8, src2=8, is_br=1, br_type=00, reg1=reg2=7 -> hz_out=1, br_taken=0. Cycle 1 has EX bubble (exe_dest=0) -> hz_out=1, hz_out_2=1, br_taken=0. Cycle 2 -> hz_out=0, br_taken=1, if_flush=1.
- ALU-to-branch: exe_wb_en=1, exe_mem_r_en=0, exe_dest=3, src1=3, is_br=1 -> hz_out=1, br_taken=0; with exe_dest=4 instead -> hz_out=0.
- Register 0: exe_mem_r_en=1, exe_dest=0, src1=0 -> hz_out=0.
- Conditions (is_br=1, no hazards):
  - BEQ with 0x12345678 vs 0x12345678 -> br_taken=1.
  - BNE with the same operands -> 0.
  - BLTZ with reg1=0x80000000 -> 1.
  - BGTZ with reg1=0 -> 0.
  - BGTZ with reg1=1 -> 1.
  - is_br=0 with equal operands -> br_taken=0, while cond_true=1 under BEQ.
- Reset mid-operation: trigger the load-to-branch case, then drop rst_n before the next edge -> hz_out_2=0 immediately, and it stays 0 after rst_n rises with no hazard present.
